// File: rtl/flag_cond_unit.sv
// flag_cond_unit: architectural flags register, branch condition evaluation with
// write-to-evaluate forwarding, and an optional LIFO flag save stack.
// Define FLAGS_STACK_EN to build the save stack; without it, the push, pop and
// error-clear inputs are ignored and StackCount/StackErr read as 0.
module flag_cond_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          FlagsWrite,
    input  logic          ArithCarryIn,
    input  logic          LogicCarryIn,
    input  logic          ZeroIn,
    input  logic          SignIn,
    input  logic          OverflowIn,
    input  logic          CondEval,
    input  logic [3:0]    CondCode,
    input  logic          CarrySel,
    input  logic          FlagsPush,
    input  logic          FlagsPop,
    input  logic          ErrClear,
    output logic          CondValid,
    output logic          CondTaken,
    output logic          ArithCarryFlag,
    output logic          LogicCarryFlag,
    output logic          ZeroFlag,
    output logic          SignFlag,
    output logic          OverflowFlag,
    output logic [CW-1:0] StackCount,
    output logic          StackErr
);
    // Flag vector layout: {arith carry, logic carry, zero, sign, overflow}
    logic [4:0] flags_q, flags_d;
    logic [4:0] flags_in;
    logic [4:0] eff;
    logic [4:0] pop_data;
    logic       pop_act;
    logic       pop_ok;
    logic       write_en;
    logic       carry;
    logic       result;
    logic       cond_valid_q, cond_valid_d;
    logic       cond_taken_q, cond_taken_d;

    assign flags_in = {ArithCarryIn, LogicCarryIn, ZeroIn, SignIn, OverflowIn};

`ifdef FLAGS_STACK_EN
    logic [4:0]    stack_q [STACK_DEPTH];
    logic [4:0]    stack_d [STACK_DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          push_ok, push_err, pop_err;

    // A simultaneous push and pop cancel out; an unpaired pop also blocks the write
    assign pop_act  = FlagsPop & ~FlagsPush;
    assign pop_ok   = pop_act & (count_q != '0);
    assign pop_err  = pop_act & (count_q == '0);
    assign push_ok  = FlagsPush & ~FlagsPop & (count_q != CW'(STACK_DEPTH));
    assign push_err = FlagsPush & ~FlagsPop & (count_q == CW'(STACK_DEPTH));

    // Top-of-stack entry is the one just below the occupancy count
    always_comb begin
        pop_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (count_q == CW'(i + 1)) pop_data = stack_q[i];
    end

    // Stack next state: push writes the forwarded flags at the count position
    always_comb begin
        stack_d = stack_q;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (push_ok && count_q == CW'(i)) stack_d[i] = eff;
        count_d = push_ok ? count_q + CW'(1) : pop_ok ? count_q - CW'(1) : count_q;
        err_d   = push_err | pop_err | (err_q & ~ErrClear);
    end

    // Stack storage needs no reset; only occupied entries are ever read
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    // Occupancy and sticky error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign StackCount = count_q;
    assign StackErr   = err_q;
`else
    logic unused_stack;

    assign pop_act      = 1'b0;
    assign pop_ok       = 1'b0;
    assign pop_data     = '0;
    assign unused_stack = ^{FlagsPush, FlagsPop, ErrClear};
    assign StackCount   = '0;
    assign StackErr     = 1'b0;
`endif

    assign write_en = FlagsWrite & ~pop_act;
    assign eff      = write_en ? flags_in : flags_q;
    assign carry    = CarrySel ? eff[3] : eff[4];

    // Condition code decode against the effective (forwarded) flags
    always_comb begin
        result = 1'b0;
        case (CondCode)
            4'h0: result = 1'b1;
            4'h1: result = 1'b0;
            4'h2: result = eff[2];
            4'h3: result = ~eff[2];
            4'h4: result = carry;
            4'h5: result = ~carry;
            4'h6: result = eff[1];
            4'h7: result = ~eff[1];
            4'h8: result = eff[0];
            4'h9: result = ~eff[0];
            4'hA: result = carry & ~eff[2];
            4'hB: result = ~carry | eff[2];
            4'hC: result = eff[1] == eff[0];
            4'hD: result = eff[1] != eff[0];
            4'hE: result = ~eff[2] & (eff[1] == eff[0]);
            4'hF: result = eff[2] | (eff[1] != eff[0]);
            default: result = 1'b0;
        endcase
    end

    // Next-state for flags and the one-deep result register
    always_comb begin
        flags_d      = pop_ok ? pop_data : write_en ? flags_in : flags_q;
        cond_valid_d = CondEval;
        cond_taken_d = CondEval ? result : cond_taken_q;
    end

    // Flags register and registered condition result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q      <= '0;
            cond_valid_q <= 1'b0;
            cond_taken_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            cond_valid_q <= cond_valid_d;
            cond_taken_q <= cond_taken_d;
        end
    end

    assign {ArithCarryFlag, LogicCarryFlag, ZeroFlag, SignFlag, OverflowFlag} = flags_q;
    assign CondValid = cond_valid_q;
    assign CondTaken = cond_taken_q;
endmodule
